// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache answering the pipeline's MEM-stage access.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_responder #(
    parameter int INDEX_W    = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_valid_i,
    input  logic                     cpu_we_i,
    input  logic [31:0]              cpu_addr_i,
    input  logic [31:0]              cpu_wdata_i,
    output logic [31:0]              cpu_rdata_o,
    output logic                     cpu_ready_o,
    output logic                     cpu_hit_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [31:0]              mem_addr_o,
    output logic [32*LINE_WORDS-1:0] mem_wdata_o,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
    input  logic                     mem_ack_i,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINES  = 1 << INDEX_W;
    localparam int TAG_W  = 32 - INDEX_W - OFF_W - 2;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];

    logic [31:0]         req_addr_q, req_addr_d;
    logic                req_we_q, req_we_d;
    logic [31:0]         req_wdata_q, req_wdata_d;

    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [OFF_W-1:0]    cpu_word;
    logic [INDEX_W-1:0]  cpu_index, req_index;
    logic [TAG_W-1:0]    cpu_tag, req_tag;
    logic [LINE_W-1:0]   victim_line;
    logic                lookup_hit;

    logic                line_we, tag_we;
    logic [INDEX_W-1:0]  line_idx;
    logic [LINE_W-1:0]   line_wdata;
    logic [TAG_W-1:0]    line_tag;
    logic                hit_evt, miss_evt;

    assign cpu_word    = cpu_addr_i[OFF_W+1:2];
    assign cpu_index   = cpu_addr_i[OFF_W+INDEX_W+1:OFF_W+2];
    assign cpu_tag     = cpu_addr_i[31:OFF_W+INDEX_W+2];
    assign req_index   = req_addr_q[OFF_W+INDEX_W+1:OFF_W+2];
    assign req_tag     = req_addr_q[31:OFF_W+INDEX_W+2];
    assign victim_line = data_q[cpu_index];
    assign lookup_hit  = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        line_idx    = cpu_index;
        line_wdata  = victim_line;
        line_tag    = req_tag;
        cpu_ready_o = 1'b0;
        cpu_hit_o   = 1'b0;
        cpu_rdata_o = 32'h0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_valid_i && lookup_hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_hit_o   = 1'b1;
                    hit_evt     = 1'b1;
                    if (cpu_we_i) begin
                        line_we                         = 1'b1;
                        line_wdata[32*cpu_word +: 32]   = cpu_wdata_i;
                        dirty_d[cpu_index]              = 1'b1;
                    end else begin
                        cpu_rdata_o = victim_line[32*cpu_word +: 32];
                    end
                end else if (cpu_valid_i) begin
                    miss_evt    = 1'b1;
                    req_addr_d  = cpu_addr_i;
                    req_we_d    = cpu_we_i;
                    req_wdata_d = cpu_wdata_i;
                    mem_req_d   = 1'b1;
                    // A dirty victim must reach memory before its slot is refilled
                    if (valid_q[cpu_index] && dirty_q[cpu_index]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[cpu_index], cpu_index, {(OFF_W+2){1'b0}}};
                        mem_wdata_d = victim_line;
                        state_d     = WRITEBACK;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {cpu_tag, cpu_index, {(OFF_W+2){1'b0}}};
                        state_d     = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                    state_d    = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    line_we            = 1'b1;
                    tag_we             = 1'b1;
                    line_idx           = req_index;
                    line_wdata         = mem_rdata_i;
                    line_tag           = req_tag;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    mem_req_d          = 1'b0;
                    mem_we_d           = 1'b0;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o     = cpu_valid_i & ~cpu_ready_o;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data arrays need no reset; the valid bits guard them
    always_ff @(posedge clk_i) begin
        if (line_we) data_q[line_idx] <= line_wdata;
        if (tag_we)  tag_q[line_idx]  <= line_tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(hit_evt);
        miss_cnt_d = miss_cnt_q + 32'(miss_evt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_evt ^ miss_evt;
    assign hit_cnt_o    = 32'h0;
    assign miss_cnt_o   = 32'h0;
`endif

    // The captured opcode and store data are kept for debug; the retried access supplies them again
    logic unused_req;
    assign unused_req = ^{cpu_addr_i[1:0], req_we_q, req_wdata_q};

endmodule

// File: tb/tb_dcache_responder.sv
// Directed self-checking bench for dcache_responder (INDEX_W=4, LINE_WORDS=4).
// Counter expectations follow DCACHE_STATS_EN the same way the design does.
module tb_dcache_responder;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         cpu_valid_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_ready_o;
    logic         cpu_hit_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [127:0] LINE1 = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    localparam logic [127:0] LINE2 = {32'h22220004, 32'h22220003, 32'h22220002, 32'h22220001};
    localparam logic [127:0] LINE3 = {32'h33330004, 32'h33330003, 32'h33330002, 32'h33330001};

    int compared   = 0;
    int mismatched = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    dcache_responder #(.INDEX_W(4), .LINE_WORDS(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cpu_valid_i(cpu_valid_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
        .cpu_hit_o(cpu_hit_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        cpu_valid_i = valid;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        #1;
    endtask

    task automatic stepClk;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "_hits"},   128'(hit_cnt_o),  STATS ? 128'(exp_hits)   : 128'(0));
        checkOutput({tag, "_misses"}, 128'(miss_cnt_o), STATS ? 128'(exp_misses) : 128'(0));
    endtask

    initial begin
        rst_ni      = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_mem_req", 128'(mem_req_o), 128'(0));
        checkOutput("rst_mem_addr", 128'(mem_addr_o), 128'(0));
        checkOutput("rst_ready", 128'(cpu_ready_o), 128'(0));
        rst_ni = 1'b1;
        checkStats("rst");

        // Cold load miss, fill, retry hit, then neighbouring word hit
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        checkOutput("s1_stall", 128'(stall_o), 128'(1));
        checkOutput("s1_ready0", 128'(cpu_ready_o), 128'(0));
        checkOutput("s1_req_c0", 128'(mem_req_o), 128'(0));
        stepClk();
        exp_misses++;
        checkOutput("s1_req", 128'(mem_req_o), 128'(1));
        checkOutput("s1_we", 128'(mem_we_o), 128'(0));
        checkOutput("s1_addr", 128'(mem_addr_o), 128'(32'h100));
        checkOutput("s1_stall_fill", 128'(stall_o), 128'(1));
        mem_rdata_i = LINE1;
        mem_ack_i   = 1'b1;
        stepClk();
        mem_ack_i   = 1'b0;
        checkOutput("s1_retry_ready", 128'(cpu_ready_o), 128'(1));
        checkOutput("s1_retry_hit", 128'(cpu_hit_o), 128'(1));
        checkOutput("s1_retry_rdata", 128'(cpu_rdata_o), 128'(32'hAAAA0001));
        checkOutput("s1_req_drop", 128'(mem_req_o), 128'(0));
        checkOutput("s1_no_stall", 128'(stall_o), 128'(0));
        stepClk();
        exp_hits++;
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h0);
        checkOutput("s1_w1_ready", 128'(cpu_ready_o), 128'(1));
        checkOutput("s1_w1_rdata", 128'(cpu_rdata_o), 128'(32'hBBBB0002));
        stepClk();
        exp_hits++;

        // Store hit then read-back
        applyStimulus(1'b1, 1'b1, 32'h108, 32'hDEADBEEF);
        checkOutput("s2_st_ready", 128'(cpu_ready_o), 128'(1));
        checkOutput("s2_st_hit", 128'(cpu_hit_o), 128'(1));
        stepClk();
        exp_hits++;
        checkOutput("s2_st_noreq", 128'(mem_req_o), 128'(0));
        applyStimulus(1'b1, 1'b0, 32'h108, 32'h0);
        checkOutput("s2_ld_rdata", 128'(cpu_rdata_o), 128'(32'hDEADBEEF));
        stepClk();
        exp_hits++;

        // Conflict miss on a dirty line: writeback then allocate
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0);
        checkOutput("s3_ready0", 128'(cpu_ready_o), 128'(0));
        stepClk();
        exp_misses++;
        checkOutput("s3_wb_req", 128'(mem_req_o), 128'(1));
        checkOutput("s3_wb_we", 128'(mem_we_o), 128'(1));
        checkOutput("s3_wb_addr", 128'(mem_addr_o), 128'(32'h100));
        checkOutput("s3_wb_data", mem_wdata_o,
                    {32'hDDDD0004, 32'hDEADBEEF, 32'hBBBB0002, 32'hAAAA0001});
        mem_ack_i = 1'b1;
        stepClk();
        mem_ack_i = 1'b0;
        checkOutput("s3_al_req", 128'(mem_req_o), 128'(1));
        checkOutput("s3_al_we", 128'(mem_we_o), 128'(0));
        checkOutput("s3_al_addr", 128'(mem_addr_o), 128'(32'h200));
        checkOutput("s3_al_ready", 128'(cpu_ready_o), 128'(0));
        checkStats("s3");

        // Asynchronous reset while allocating
        #2;
        rst_ni = 1'b0;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        checkOutput("s4_req_async", 128'(mem_req_o), 128'(0));
        checkStats("s4_rst");
        #2;
        rst_ni = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        checkOutput("s4_remiss", 128'(cpu_ready_o), 128'(0));
        stepClk();
        exp_misses++;
        checkOutput("s4_req", 128'(mem_req_o), 128'(1));
        checkOutput("s4_we_fill", 128'(mem_we_o), 128'(0));
        checkOutput("s4_addr", 128'(mem_addr_o), 128'(32'h100));

        // Long ack delay; CPU inputs change but must be ignored
        applyStimulus(1'b1, 1'b1, 32'h440, 32'h55555555);
        for (int i = 0; i < 20; i++) begin
            stepClk();
            checkOutput("s5_hold_req", 128'(mem_req_o), 128'(1));
            checkOutput("s5_hold_addr", 128'(mem_addr_o), 128'(32'h100));
            checkOutput("s5_hold_stall", 128'(stall_o), 128'(1));
        end
        checkStats("s5_hold");
        mem_rdata_i = LINE2;
        mem_ack_i   = 1'b1;
        stepClk();
        mem_ack_i   = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h10C, 32'h0);
        checkOutput("s5_w3_ready", 128'(cpu_ready_o), 128'(1));
        checkOutput("s5_w3_rdata", 128'(cpu_rdata_o), 128'(32'h22220004));
        stepClk();
        exp_hits++;

        // Stray ack with nothing outstanding
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack_i = 1'b1;
        stepClk();
        mem_ack_i = 1'b0;
        checkOutput("s5_stray_req", 128'(mem_req_o), 128'(0));
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        checkOutput("s5_stray_hit", 128'(cpu_hit_o), 128'(1));
        checkOutput("s5_stray_rdata", 128'(cpu_rdata_o), 128'(32'h22220001));
        stepClk();
        exp_hits++;

        // Store miss on a clean line: allocate, retry sets dirty
        applyStimulus(1'b1, 1'b1, 32'h304, 32'h12345678);
        checkOutput("s6_st_miss", 128'(cpu_ready_o), 128'(0));
        stepClk();
        exp_misses++;
        checkOutput("s6_we_fill", 128'(mem_we_o), 128'(0));
        checkOutput("s6_addr", 128'(mem_addr_o), 128'(32'h300));
        mem_rdata_i = LINE3;
        mem_ack_i   = 1'b1;
        stepClk();
        mem_ack_i   = 1'b0;
        checkOutput("s6_retry_ready", 128'(cpu_ready_o), 128'(1));
        stepClk();
        exp_hits++;

        // Evict the stored line, with the CPU abandoning the access mid-miss
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        stepClk();
        exp_misses++;
        checkOutput("s7_wb_we", 128'(mem_we_o), 128'(1));
        checkOutput("s7_wb_addr", 128'(mem_addr_o), 128'(32'h300));
        checkOutput("s7_wb_data", mem_wdata_o,
                    {32'h33330004, 32'h33330003, 32'h12345678, 32'h33330001});
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack_i = 1'b1;
        stepClk();
        checkOutput("s7_al_addr", 128'(mem_addr_o), 128'(32'h100));
        mem_rdata_i = LINE1;
        stepClk();
        mem_ack_i = 1'b0;
        checkOutput("s7_no_ready", 128'(cpu_ready_o), 128'(0));
        checkOutput("s7_req_drop", 128'(mem_req_o), 128'(0));
        checkOutput("s7_no_stall", 128'(stall_o), 128'(0));
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        checkOutput("s7_filled_hit", 128'(cpu_hit_o), 128'(1));
        checkOutput("s7_filled_rdata", 128'(cpu_rdata_o), 128'(32'hAAAA0001));
        stepClk();
        exp_hits++;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkStats("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
